// File: rtl/udp_reg_ring_master_pkg.sv
// -----------------------------------------------------------------------------
// udp_reg_ring_master_pkg
// Shared definitions for the user-data-path register ring master.
//   - Default bus widths for the ring address and data fields. They are macros
//     so that a system-level include may override them before this file.
//   - FSM state encoding (2-bit) for the master.
//   - Default read data returned when a transaction is not acknowledged.
//   - A helper that selects the read data returned to the core on an acked
//     response.
// -----------------------------------------------------------------------------
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 16
`endif

`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

package udp_reg_ring_master_pkg;

  localparam int UDP_REG_ADDR_WIDTH  = `UDP_REG_ADDR_WIDTH;
  localparam int CPCI_NF2_DATA_WIDTH = `CPCI_NF2_DATA_WIDTH;

  // Value handed back to the core when nobody claimed the access.
  localparam logic [CPCI_NF2_DATA_WIDTH-1:0] NO_ACK_DATA_DEFAULT = 'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Read data for an acknowledged response: reads return the ring data,
  // writes complete with zero.
  function automatic logic [CPCI_NF2_DATA_WIDTH-1:0] acked_rd_data(
    input logic                           is_read,
    input logic [CPCI_NF2_DATA_WIDTH-1:0] ring_data
  );
    return is_read ? ring_data : '0;
  endfunction

endpackage

// File: rtl/udp_reg_ring_master.sv
// -----------------------------------------------------------------------------
// udp_reg_ring_master
// Initiator end of the user-data-path register ring. It owns both the head
// (reg_*_out) and the tail (reg_*_in) of the ring: a core-side transaction is
// launched as a single-cycle request on the head and completed when the same
// request comes back around on the tail, or when the wait times out.
//
// Ports
//   clk, reset          single clock, asynchronous active-high reset
//   core_reg_req        1-cycle strobe, ignored while a transaction is in flight
//   core_reg_rd_wr_L    1 = read, 0 = write (sampled with core_reg_req)
//   core_reg_addr       target register address
//   core_reg_wr_data    write data
//   core_reg_busy       transaction in flight (accept until completion)
//   core_reg_ack        1-cycle completion pulse
//   core_reg_err        with ack: 1 = not acknowledged or timed out
//   core_reg_rd_data    with ack: read data (held until the next completion)
//   reg_*_out           ring head: req/ack/rd_wr_L/addr/data/src
//   reg_*_in            ring tail: req/ack/rd_wr_L/addr/data/src
//
// Every output is a register. The master terminates the ring: anything that
// arrives on the tail outside the wait window, or carrying another source
// tag, is dropped and never forwarded.
// -----------------------------------------------------------------------------
module udp_reg_ring_master
  import udp_reg_ring_master_pkg::*;
#(
  parameter int                                UDP_REG_SRC_WIDTH = 2,
  parameter logic [UDP_REG_SRC_WIDTH-1:0]      SRC_ID            = '0,
  parameter int                                TIMEOUT           = 64,
  parameter logic [`CPCI_NF2_DATA_WIDTH-1:0]   NO_ACK_DATA       = NO_ACK_DATA_DEFAULT
) (
  input  logic                                clk,
  input  logic                                reset,

  // core side
  input  logic                                core_reg_req,
  input  logic                                core_reg_rd_wr_L,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]      core_reg_addr,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]     core_reg_wr_data,
  output logic                                core_reg_busy,
  output logic                                core_reg_ack,
  output logic                                core_reg_err,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]     core_reg_rd_data,

  // ring head
  output logic                                reg_req_out,
  output logic                                reg_ack_out,
  output logic                                reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]      reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]        reg_src_out,

  // ring tail
  input  logic                                reg_req_in,
  input  logic                                reg_ack_in,
  input  logic                                reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]      reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]        reg_src_in
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             resp_match;

  // Only one transaction is ever outstanding, so the source tag alone
  // identifies our response; the returned address and direction are not
  // needed.
  assign resp_match = reg_req_in && (reg_src_in == SRC_ID);

  logic unused_tail;
  assign unused_tail = ^{reg_rd_wr_L_in, reg_addr_in};

  // The head output registers double as the latched copy of the accepted
  // transaction: they are loaded on accept and held until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      wait_cnt         <= '0;
      core_reg_busy    <= 1'b0;
      core_reg_ack     <= 1'b0;
      core_reg_err     <= 1'b0;
      core_reg_rd_data <= '0;
      reg_req_out      <= 1'b0;
      reg_ack_out      <= 1'b0;
      reg_rd_wr_L_out  <= 1'b0;
      reg_addr_out     <= '0;
      reg_data_out     <= '0;
      reg_src_out      <= '0;
    end else begin
      core_reg_ack <= 1'b0;

      case (state)
        // ---- accept a core transaction and drive the head request ----
        ST_IDLE: begin
          if (core_reg_req) begin
            state           <= ST_ISSUE;
            core_reg_busy   <= 1'b1;
            reg_req_out     <= 1'b1;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= core_reg_rd_wr_L;
            reg_addr_out    <= core_reg_addr;
            reg_data_out    <= core_reg_rd_wr_L ? '0 : core_reg_wr_data;
            reg_src_out     <= SRC_ID;
          end
        end

        // ---- request visible on the head for exactly one cycle ----
        ST_ISSUE: begin
          reg_req_out <= 1'b0;
          wait_cnt    <= '0;
          state       <= ST_WAIT;
        end

        // ---- wait for our request to return; response beats timeout ----
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (resp_match) begin
            state         <= ST_DONE;
            core_reg_ack  <= 1'b1;
            core_reg_busy <= 1'b0;
            if (reg_ack_in) begin
              core_reg_err     <= 1'b0;
              core_reg_rd_data <= acked_rd_data(reg_rd_wr_L_out, reg_data_in);
            end else begin
              core_reg_err     <= 1'b1;
              core_reg_rd_data <= NO_ACK_DATA;
            end
          end else if (wait_cnt == CNT_LAST) begin
            state            <= ST_DONE;
            core_reg_ack     <= 1'b1;
            core_reg_busy    <= 1'b0;
            core_reg_err     <= 1'b1;
            core_reg_rd_data <= NO_ACK_DATA;
          end
        end

        // ---- completion cycle: ack is high, no new accept yet ----
        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_reg_ring_master.sv
module tb_udp_reg_ring_master;
  import udp_reg_ring_master_pkg::*;

  localparam int            AW    = UDP_REG_ADDR_WIDTH;
  localparam int            DW    = CPCI_NF2_DATA_WIDTH;
  localparam int            SW    = 2;
  localparam logic [SW-1:0] SRC   = 2'd0;
  localparam int            TMO   = 64;
  localparam logic [DW-1:0] NOACK = 'hDEAD;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          core_reg_req = 1'b0;
  logic          core_reg_rd_wr_L = 1'b0;
  logic [AW-1:0] core_reg_addr = '0;
  logic [DW-1:0] core_reg_wr_data = '0;
  logic          core_reg_busy, core_reg_ack, core_reg_err;
  logic [DW-1:0] core_reg_rd_data;
  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [SW-1:0] reg_src_out;
  logic          reg_req_in = 1'b0, reg_ack_in = 1'b0, reg_rd_wr_L_in = 1'b0;
  logic [AW-1:0] reg_addr_in = '0;
  logic [DW-1:0] reg_data_in = '0;
  logic [SW-1:0] reg_src_in = '0;

  udp_reg_ring_master #(
    .UDP_REG_SRC_WIDTH(SW), .SRC_ID(SRC), .TIMEOUT(TMO), .NO_ACK_DATA(NOACK)
  ) dut (
    .clk(clk), .reset(reset),
    .core_reg_req(core_reg_req), .core_reg_rd_wr_L(core_reg_rd_wr_L),
    .core_reg_addr(core_reg_addr), .core_reg_wr_data(core_reg_wr_data),
    .core_reg_busy(core_reg_busy), .core_reg_ack(core_reg_ack),
    .core_reg_err(core_reg_err), .core_reg_rd_data(core_reg_rd_data),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out),
    .reg_rd_wr_L_out(reg_rd_wr_L_out), .reg_addr_out(reg_addr_out),
    .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in),
    .reg_rd_wr_L_in(reg_rd_wr_L_in), .reg_addr_in(reg_addr_in),
    .reg_data_in(reg_data_in), .reg_src_in(reg_src_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Tracks a transaction by its age in cycles since accept:
  //   age 1 ends the request cycle; ages 2.. are the wait window, and the
  //   wait cycle number (age-2) reaching TMO-1 without a response times out.
  //   The cycle after completion cannot accept.
  logic          m_busy = 0, m_ack = 0, m_err = 0, m_req = 0, m_rdwr = 0;
  logic [DW-1:0] m_rd = '0, m_data = '0;
  logic [AW-1:0] m_addr = '0;
  logic [SW-1:0] m_src = '0;
  bit            in_flight = 0, cooldown = 0;
  int            age = 0;

  task automatic m_complete(input logic ok, input logic [DW-1:0] d);
    m_ack = 1; m_busy = 0; in_flight = 0; cooldown = 1;
    m_err = !ok;
    m_rd  = ok ? (m_rdwr ? d : '0) : NOACK;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_busy = 0; m_ack = 0; m_err = 0; m_req = 0; m_rdwr = 0;
        m_rd = '0; m_data = '0; m_addr = '0; m_src = '0;
        in_flight = 0; cooldown = 0;
      end else begin
        m_ack = 0;
        if (in_flight) begin
          age++;
          if (age == 1) m_req = 0;
          else if (reg_req_in && reg_src_in == SRC) m_complete(reg_ack_in, reg_data_in);
          else if (age - 2 == TMO - 1) m_complete(1'b0, '0);
        end else if (cooldown) begin
          cooldown = 0;
        end else if (core_reg_req) begin
          in_flight = 1; age = 0;
          m_busy = 1; m_req = 1; m_rdwr = core_reg_rd_wr_L;
          m_addr = core_reg_addr;
          m_data = core_reg_rd_wr_L ? '0 : core_reg_wr_data;
          m_src  = SRC;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("busy",     core_reg_busy,    m_busy);
      chk("ack",      core_reg_ack,     m_ack);
      chk("err",      core_reg_err,     m_err);
      chk("rd_data",  core_reg_rd_data, m_rd);
      chk("req_out",  reg_req_out,      m_req);
      chk("ack_out",  reg_ack_out,      1'b0);
      chk("rdwr_out", reg_rd_wr_L_out,  m_rdwr);
      chk("addr_out", reg_addr_out,     m_addr);
      chk("data_out", reg_data_out,     m_data);
      chk("src_out",  reg_src_out,      m_src);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_ring();
    reg_req_in = 0; reg_ack_in = 0; reg_rd_wr_L_in = 0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
  endtask

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
  task automatic strobe(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_reg_req = 1; core_reg_rd_wr_L = rd; core_reg_addr = a; core_reg_wr_data = d;
    tick();
    core_reg_req = 0;
  endtask

  // Presents one tail beat for the current cycle; returns one cycle later.
  task automatic respond(input logic ack, input logic [DW-1:0] d, input logic [SW-1:0] src);
    reg_req_in = 1; reg_ack_in = ack; reg_data_in = d; reg_src_in = src;
    reg_rd_wr_L_in = reg_rd_wr_L_out; reg_addr_in = reg_addr_out;
    tick();
    idle_ring();
  endtask

  task automatic wait_ack(input int limit, output int n);
    n = 0;
    while (!core_reg_ack && n < limit) begin
      tick();
      n++;
    end
    chk("ack_within_bound", core_reg_ack, 1'b1);
  endtask

  initial begin
    int n;
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) tick();
    reset = 0;
    tick();
    chk("rst_busy", core_reg_busy, 1'b0);
    chk("rst_ack",  core_reg_ack, 1'b0);
    chk("rst_req",  reg_req_out, 1'b0);
    chk("rst_rd",   core_reg_rd_data, 32'h0);

    // Read, acked after 5 cycles.
    strobe(1'b1, 16'h0040, '0);
    chk("rd_head_req_c1", reg_req_out, 1'b1);
    chk("rd_head_addr",   reg_addr_out, 16'h0040);
    chk("rd_head_data",   reg_data_out, 32'h0);
    tick();
    chk("rd_head_req_c2", reg_req_out, 1'b0);
    repeat (3) tick();
    respond(1'b1, 32'h1234, SRC);
    chk("rd_ack",  core_reg_ack, 1'b1);
    chk("rd_err",  core_reg_err, 1'b0);
    chk("rd_data", core_reg_rd_data, 32'h1234);
    chk("rd_busy_drop", core_reg_busy, 1'b0);
    tick();
    chk("rd_ack_pulse", core_reg_ack, 1'b0);
    chk("rd_data_hold", core_reg_rd_data, 32'h1234);

    // Write, acked.
    strobe(1'b0, 16'h0042, 32'hBEEF);
    chk("wr_head_data", reg_data_out, 32'hBEEF);
    chk("wr_head_rdwr", reg_rd_wr_L_out, 1'b0);
    repeat (2) tick();
    respond(1'b1, 32'h5555, SRC);
    chk("wr_ack", core_reg_ack, 1'b1);
    chk("wr_err", core_reg_err, 1'b0);
    chk("wr_rd",  core_reg_rd_data, 32'h0);
    tick();

    // Looped back without ack.
    strobe(1'b1, 16'h0044, '0);
    tick();
    respond(1'b0, 32'h7777, SRC);
    chk("noack_ack", core_reg_ack, 1'b1);
    chk("noack_err", core_reg_err, 1'b1);
    chk("noack_rd",  core_reg_rd_data, 32'hDEAD);
    tick();

    // Filtering: stray tail beat in idle, foreign src, second strobe while busy.
    tick();
    respond(1'b1, 32'h1111, SRC);
    chk("stray_idle_ack", core_reg_ack, 1'b0);
    strobe(1'b1, 16'h0050, '0);
    tick();
    respond(1'b1, 32'h2222, 2'd1);
    chk("foreign_ack",  core_reg_ack, 1'b0);
    chk("foreign_busy", core_reg_busy, 1'b1);
    strobe(1'b0, 16'h0060, 32'h9999);
    chk("busy_strobe_req",  reg_req_out, 1'b0);
    chk("busy_strobe_addr", reg_addr_out, 16'h0050);
    respond(1'b1, 32'h3333, SRC);
    chk("filter_ack", core_reg_ack, 1'b1);
    chk("filter_rd",  core_reg_rd_data, 32'h3333);
    tick();

    // Timeout: ring never returns the request.
    strobe(1'b1, 16'h0070, '0);
    wait_ack(100, n);
    chk("timeout_cycle", n + 1, 66);
    chk("timeout_err",   core_reg_err, 1'b1);
    chk("timeout_rd",    core_reg_rd_data, 32'hDEAD);
    tick();

    // Reset in the middle of the wait, then a late response.
    strobe(1'b0, 16'h0080, 32'hCAFE);
    repeat (3) tick();
    reset = 1;
    tick();
    chk("mrst_busy", core_reg_busy, 1'b0);
    chk("mrst_addr", reg_addr_out, 16'h0);
    chk("mrst_data", reg_data_out, 32'h0);
    tick();
    reset = 0;
    tick();
    respond(1'b1, 32'h4444, SRC);
    chk("late_resp_ack",  core_reg_ack, 1'b0);
    chk("late_resp_busy", core_reg_busy, 1'b0);
    strobe(1'b1, 16'h0090, '0);
    tick();
    respond(1'b1, 32'hABCD, SRC);
    chk("post_rst_ack", core_reg_ack, 1'b1);
    chk("post_rst_rd",  core_reg_rd_data, 32'hABCD);
    tick();

    // Randomized transactions with tail noise and ignored strobes.
    for (int t = 0; t < 40; t++) begin
      int dly;
      int mode;
      dly  = $urandom_range(0, 8);
      mode = $urandom_range(0, 9);
      strobe(1'($urandom), AW'($urandom), DW'($urandom));
      for (int d = 0; d < dly; d++) begin
        reg_req_in  = ($urandom % 3 == 0);
        reg_src_in  = SW'(1 + $urandom % 3);
        reg_ack_in  = 1'($urandom);
        reg_data_in = DW'($urandom);
        core_reg_req = ($urandom % 4 == 0);
        core_reg_rd_wr_L = 1'($urandom);
        core_reg_addr = AW'($urandom);
        core_reg_wr_data = DW'($urandom);
        tick();
      end
      core_reg_req = 0;
      idle_ring();
      if (mode != 0) respond(($urandom % 4) != 0, DW'($urandom), SRC);
      wait_ack(100, n);
      tick();
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
